// File: rtl/scalar_pkg.sv
// Shared definitions for the scalar write-back path.
//   DATA_W       scalar data width
//   NREG         number of scalar registers
//   IDX_W        register index width
//   buf_state_e  one-entry load buffer state
package scalar_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/scalar_wb_scoreboard.sv
// Pending-write scoreboard for the scalar register file.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rsv_en, rsv_dst           reserve a destination (sets its pending bit)
//   clr_en, clr_dst           write selected for a destination (clears its pending bit)
//   chk_addr_1, chk_addr_2    source registers to look up
//   hazard                    combinational: either source has its pending bit set
//   pending                   pending bit per register
module scalar_wb_scoreboard
  import scalar_pkg::*;
#(
  parameter int unsigned NREG = scalar_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsv_en,
  input  logic [IDX_W-1:0] rsv_dst,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_dst,
  input  logic [IDX_W-1:0] chk_addr_1,
  input  logic [IDX_W-1:0] chk_addr_2,
  output logic             hazard,
  output logic [NREG-1:0]  pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear is applied first so a same-edge reservation of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_dst] = 1'b0;
    end
    if (rsv_en) begin
      pending_d[rsv_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign hazard  = pending_q[chk_addr_1] | pending_q[chk_addr_2];

endmodule

// File: rtl/scalar_wb_ctrl.sv
// Scalar write-back controller: merges ALU and load results onto a single registered
// register-file write port, with a one-entry load buffer and a pending-write scoreboard.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_dst/alu_data    ALU result, always accepted
//   ld_valid/ld_dst/ld_data       load result, accepted when ld_valid & ld_ready
//   ld_ready                      high only while the load buffer is empty
//   rsv_en/rsv_dst                destination reservation from issue
//   chk_addr_1/chk_addr_2         issue-stage source registers
//   hazard                        combinational source hazard
//   pending                       pending-write bit per register
//   wr_en/wr_dst/wr_data          registered register-file write port
module scalar_wb_ctrl
  import scalar_pkg::*;
#(
  parameter int unsigned DATA_W = scalar_pkg::DATA_W,
  parameter int unsigned NREG   = scalar_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              rsv_en,
  input  logic [IDX_W-1:0]  rsv_dst,
  input  logic [IDX_W-1:0]  chk_addr_1,
  input  logic [IDX_W-1:0]  chk_addr_2,
  output logic              hazard,
  output logic [NREG-1:0]   pending,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_dst,
  output logic [DATA_W-1:0] wr_data
);

  buf_state_e        state_q;
  logic [IDX_W-1:0]  buf_dst_q;
  logic [DATA_W-1:0] buf_data_q;

  logic              ld_xfer;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_dst;
  logic [DATA_W-1:0] sel_data;

  // Ready depends only on the state register, never on same-cycle inputs.
  assign ld_ready = (state_q == EMPTY);
  assign ld_xfer  = ld_valid & ld_ready;

  // Source priority: ALU, then buffered load, then direct load.
  always_comb begin
    sel_valid = 1'b0;
    sel_dst   = alu_dst;
    sel_data  = alu_data;
    if (alu_valid) begin
      sel_valid = 1'b1;
    end else if (state_q == FULL) begin
      sel_valid = 1'b1;
      sel_dst   = buf_dst_q;
      sel_data  = buf_data_q;
    end else if (ld_xfer) begin
      sel_valid = 1'b1;
      sel_dst   = ld_dst;
      sel_data  = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      buf_dst_q  <= '0;
      buf_data_q <= '0;
      wr_en      <= 1'b0;
      wr_dst     <= '0;
      wr_data    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          // A load accepted alongside an ALU result has to wait one slot.
          if (ld_xfer && alu_valid) begin
            state_q    <= FULL;
            buf_dst_q  <= ld_dst;
            buf_data_q <= ld_data;
          end
        end
        FULL: begin
          if (!alu_valid) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase

      wr_en <= sel_valid;
      if (sel_valid) begin
        wr_dst  <= sel_dst;
        wr_data <= sel_data;
      end
    end
  end

  scalar_wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en     (rsv_en),
    .rsv_dst    (rsv_dst),
    .clr_en     (sel_valid),
    .clr_dst    (sel_dst),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .hazard     (hazard),
    .pending    (pending)
  );

endmodule

// File: tb/tb_scalar_wb_ctrl.sv
// Bench for scalar_wb_ctrl: expected writes are queued as stimulus is driven and
// popped by a monitor whenever the write port fires.
module tb_scalar_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_dst = '0;
  logic [15:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_dst = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        rsv_en = 1'b0;
  logic [2:0]  rsv_dst = '0;
  logic [2:0]  chk_addr_1 = '0;
  logic [2:0]  chk_addr_2 = '0;
  logic        hazard;
  logic [7:0]  pending;
  logic        wr_en;
  logic [2:0]  wr_dst;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;

  logic [18:0] exp_q[$];
  bit          m_full = 1'b0;
  logic [2:0]  m_buf_dst = '0;
  logic [15:0] m_buf_data = '0;
  logic [7:0]  m_pending = '0;

  scalar_wb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_dst    (alu_dst),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_dst     (ld_dst),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .rsv_en     (rsv_en),
    .rsv_dst    (rsv_dst),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .hazard     (hazard),
    .pending    (pending),
    .wr_en      (wr_en),
    .wr_dst     (wr_dst),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  // Every visible write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got dst=%0d data=%h, none expected", wr_dst, wr_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({wr_dst, wr_data} !== e) begin
          failures++;
          $display("FAIL write_order: got dst=%0d data=%h expected dst=%0d data=%h",
                   wr_dst, wr_data, e[18:16], e[15:0]);
        end
      end
    end
  end

  // Drive one clock edge worth of stimulus and advance the reference model.
  // Returns at posedge+1 with all valids deasserted.
  task automatic drive_cycle(input bit av, input logic [2:0] ad, input logic [15:0] adata,
                             input bit lv, input logic [2:0] ldd, input logic [15:0] ldata,
                             input bit rv, input logic [2:0] rd);
    bit         ld_x;
    bit         sv;
    logic [2:0] sd;
    alu_valid = av;  alu_dst = ad;  alu_data = adata;
    ld_valid  = lv;  ld_dst  = ldd; ld_data  = ldata;
    rsv_en    = rv;  rsv_dst = rd;
    ld_x = lv && !m_full;
    sv   = 1'b0;
    sd   = '0;
    if (av) begin
      exp_q.push_back({ad, adata});
      sv = 1'b1; sd = ad;
      if (ld_x) begin
        m_full = 1'b1; m_buf_dst = ldd; m_buf_data = ldata;
      end
    end else if (m_full) begin
      exp_q.push_back({m_buf_dst, m_buf_data});
      sv = 1'b1; sd = m_buf_dst;
      m_full = 1'b0;
    end else if (ld_x) begin
      exp_q.push_back({ldd, ldata});
      sv = 1'b1; sd = ldd;
    end
    if (sv) m_pending[sd] = 1'b0;
    if (rv) m_pending[rd] = 1'b1;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    rsv_en    = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_addr_1 = 3'd0;
    chk_addr_2 = 3'd0;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      failures++; $display("FAIL reset_wr_en: got %b expected 0", wr_en);
    end
    checks++;
    if (pending !== 8'h00) begin
      failures++; $display("FAIL reset_pending: got %h expected 00", pending);
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    end
    checks++;
    if (hazard !== 1'b0) begin
      failures++; $display("FAIL reset_hazard: got %b expected 0", hazard);
    end
    checks++;
    if ({wr_dst, wr_data} !== 19'h0) begin
      failures++; $display("FAIL reset_wr_port: got %h expected 0", {wr_dst, wr_data});
    end
  endtask

  task automatic test_hazard();
    drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
    chk_addr_1 = 3'd3;
    chk_addr_2 = 3'd0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++; $display("FAIL hazard_set: got %b expected 1", hazard);
    end
    drive_cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    checks++;
    if (hazard !== 1'b0 || pending[3] !== 1'b0) begin
      failures++; $display("FAIL hazard_clear: got hazard=%b pending=%h expected 0/0",
                           hazard, pending);
    end
    checks++;
    if ({wr_en, wr_dst, wr_data} !== {1'b1, 3'd3, 16'hBEEF}) begin
      failures++; $display("FAIL hazard_write: got en=%b dst=%0d data=%h expected 1/3/beef",
                           wr_en, wr_dst, wr_data);
    end
    chk_addr_1 = 3'd0;
  endtask

  task automatic test_alu_load_collision();
    drive_cycle(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 3'd0);
    checks++;
    if ({ld_ready, wr_en, wr_dst} !== {1'b0, 1'b1, 3'd1}) begin
      failures++; $display("FAIL collision_c1: got ready=%b en=%b dst=%0d expected 0/1/1",
                           ld_ready, wr_en, wr_dst);
    end
    idle_cycle();
    checks++;
    if ({ld_ready, wr_en, wr_dst, wr_data} !== {1'b1, 1'b1, 3'd2, 16'h0022}) begin
      failures++; $display("FAIL collision_c2: got ready=%b en=%b dst=%0d data=%h expected 1/1/2/0022",
                           ld_ready, wr_en, wr_dst, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] dsts [3];
    dsts[0] = 3'd4; dsts[1] = 3'd5; dsts[2] = 3'd6;
    drive_cycle(1'b1, 3'd0, 16'h1000, 1'b1, 3'd2, 16'h0022, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, dsts[i], 16'h4440 + 16'(i), 1'b1, 3'd7, 16'hDEAD, 1'b0, 3'd0);
      checks++;
      if ({ld_ready, wr_dst} !== {1'b0, dsts[i]}) begin
        failures++; $display("FAIL b2b_alu_%0d: got ready=%b dst=%0d expected 0/%0d",
                             i, ld_ready, wr_dst, dsts[i]);
      end
    end
    idle_cycle();
    checks++;
    if ({ld_ready, wr_en, wr_dst, wr_data} !== {1'b1, 1'b1, 3'd2, 16'h0022}) begin
      failures++; $display("FAIL b2b_drain: got ready=%b en=%b dst=%0d data=%h expected 1/1/2/0022",
                           ld_ready, wr_en, wr_dst, wr_data);
    end
  endtask

  task automatic test_set_wins();
    drive_cycle(1'b1, 3'd5, 16'h0555, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    checks++;
    if (pending[5] !== 1'b1) begin
      failures++; $display("FAIL set_wins: got pending=%h expected bit5=1", pending);
    end
    drive_cycle(1'b1, 3'd5, 16'h0556, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    checks++;
    if (pending !== m_pending) begin
      failures++; $display("FAIL clear_r5: got pending=%h expected %h", pending, m_pending);
    end
    // Write to a register that was never reserved leaves pending alone.
    drive_cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h0111, 1'b0, 3'd0);
    checks++;
    if (pending !== m_pending) begin
      failures++; $display("FAIL nonpending_write: got pending=%h expected %h", pending, m_pending);
    end
  endtask

  task automatic test_reset_while_full();
    drive_cycle(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0077, 1'b1, 3'd6);
    checks++;
    if ({ld_ready, pending[6]} !== 2'b01) begin
      failures++; $display("FAIL rwf_setup: got ready=%b pend6=%b expected 0/1", ld_ready, pending[6]);
    end
    // Reset with live inputs: none of them may take effect.
    rst = 1'b1;
    alu_valid = 1'b1; alu_dst = 3'd3; alu_data = 16'h3333;
    ld_valid = 1'b1;  ld_dst = 3'd4;  ld_data = 16'h4444;
    rsv_en = 1'b1;    rsv_dst = 3'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; rsv_en = 1'b0;
    m_full = 1'b0;
    m_pending = '0;
    checks++;
    if ({ld_ready, wr_en, pending} !== {1'b1, 1'b0, 8'h00}) begin
      failures++; $display("FAIL rwf_after: got ready=%b en=%b pending=%h expected 1/0/00",
                           ld_ready, wr_en, pending);
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      checks++;
      if (wr_en !== 1'b0) begin
        failures++; $display("FAIL rwf_no_write_%0d: got en=%b expected 0", i, wr_en);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 2) == 0, 3'($urandom));
      chk_addr_1 = 3'($urandom);
      chk_addr_2 = 3'($urandom);
      #1;
      checks++;
      if (pending !== m_pending) begin
        failures++; $display("FAIL rand_pending_%0d: got %h expected %h", i, pending, m_pending);
      end
      checks++;
      if (hazard !== (m_pending[chk_addr_1] | m_pending[chk_addr_2])) begin
        failures++; $display("FAIL rand_hazard_%0d: got %b expected %b", i, hazard,
                             m_pending[chk_addr_1] | m_pending[chk_addr_2]);
      end
      checks++;
      if (ld_ready !== !m_full) begin
        failures++; $display("FAIL rand_ld_ready_%0d: got %b expected %b", i, ld_ready, !m_full);
      end
    end
    for (int i = 0; i < 3; i++) idle_cycle();
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_alu_load_collision();
    test_back_to_back();
    test_set_wins();
    test_reset_while_full();
    test_random();
    idle_cycle();
    idle_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
